// File: rtl/video_timing_ctrl.sv
// Raster timing generator for the TMDS output path: x/y coordinates and pixel
// requests, with sync/active delayed LEAD cycles to match pixel-source latency.
module video_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned LEAD     = 2
) (
    input  logic        pixclk,
    input  logic        rst_n,
    input  logic        en,
    output logic [11:0] x,
    output logic [10:0] y,
    output logic        req,
    output logic        frame_start,
    output logic        line_start,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        running
);

    localparam int unsigned XW      = 12;
    localparam int unsigned YW      = 11;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            frame_last;
    logic [XW-1:0]   x_d;
    logic [YW-1:0]   y_d;
    logic            run_d;
    logic            req_d;
    logic            fs_d;
    logic            ls_d;
    logic            hs_d;
    logic            vs_d;
    logic [2:0]      tap;

    assign frame_last = (x == XW'(H_TOTAL - 1)) && (y == YW'(V_TOTAL - 1));

    // State register
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Run control: stopping only lands in IDLE on the last pixel of a frame
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (en) state_next = ST_RUN;
            ST_RUN:  if (!en) state_next = ST_STOP;
            ST_STOP: begin
                if (en) begin
                    state_next = ST_RUN;
                end else if (frame_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Next coordinate-stage values, decoded from the next counter values
    always_comb begin
        x_d   = '0;
        y_d   = '0;
        run_d = (state_next != ST_IDLE);
        if (state != ST_IDLE) begin
            if (x == XW'(H_TOTAL - 1)) begin
                x_d = '0;
                y_d = (y == YW'(V_TOTAL - 1)) ? '0 : y + YW'(1);
            end else begin
                x_d = x + XW'(1);
                y_d = y;
            end
        end
        if (!run_d) begin
            x_d = '0;
            y_d = '0;
        end
        req_d = run_d && (32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE);
        fs_d  = run_d && (x_d == '0) && (y_d == '0);
        ls_d  = run_d && (x_d == '0);
        hs_d  = run_d && (32'(x_d) >= HS_BEG) && (32'(x_d) < HS_END);
        vs_d  = run_d && (32'(y_d) >= VS_BEG) && (32'(y_d) < VS_END);
    end

    // Coordinate-stage registers
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            req         <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            running     <= 1'b0;
        end else begin
            x           <= x_d;
            y           <= y_d;
            req         <= req_d;
            frame_start <= fs_d;
            line_start  <= ls_d;
            running     <= run_d;
        end
    end

    // Delay line for {hs, vs, req}; stage 0 is the coordinate-stage copy
    if (LEAD == 0) begin : g_direct
        assign tap = {hs_d, vs_d, req_d};
    end else begin : g_pipe
        logic [2:0] pipe [LEAD];

        always_ff @(posedge pixclk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(LEAD); i++) begin
                    pipe[i] <= 3'b000;
                end
            end else begin
                pipe[0] <= {hs_d, vs_d, req_d};
                for (int i = 1; i < int'(LEAD); i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign tap = pipe[LEAD-1];
    end

    // Output stage with polarity applied
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            hsync  <= ~HS_POL;
            vsync  <= ~VS_POL;
            active <= 1'b0;
        end else begin
            hsync  <= tap[2] ? HS_POL : ~HS_POL;
            vsync  <= tap[1] ? VS_POL : ~VS_POL;
            active <= tap[0];
        end
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: small raster, two builds (LEAD=2 active-high,
// LEAD=0 active-low), checked every cycle against a frame-position model.
module tb_video_timing_ctrl;

    localparam int HT = 16;
    localparam int VT = 8;
    localparam int FT = HT * VT;

    logic pixclk = 1'b0;
    logic rst_n  = 1'b1;
    logic en     = 1'b0;

    logic [11:0] a_x, b_x;
    logic [10:0] a_y, b_y;
    logic a_req, a_fs, a_ls, a_hs, a_vs, a_act, a_run;
    logic b_req, b_fs, b_ls, b_hs, b_vs, b_act, b_run;

    always #5 pixclk = ~pixclk;

    video_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .LEAD(2)
    ) u_a (
        .pixclk(pixclk), .rst_n(rst_n), .en(en),
        .x(a_x), .y(a_y), .req(a_req), .frame_start(a_fs), .line_start(a_ls),
        .hsync(a_hs), .vsync(a_vs), .active(a_act), .running(a_run)
    );

    video_timing_ctrl #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .LEAD(0)
    ) u_b (
        .pixclk(pixclk), .rst_n(rst_n), .en(en),
        .x(b_x), .y(b_y), .req(b_req), .frame_start(b_fs), .line_start(b_ls),
        .hsync(b_hs), .vsync(b_vs), .active(b_act), .running(b_run)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // Model: running flag, stop request, linear position within the frame
    bit m_run, m_stop;
    int p;
    bit [2:0] r0, r1, r2;   // {hs, vs, req} now, 1 and 2 cycles ago
    int e_x, e_y;
    bit e_req, e_fs, e_ls;

    bit win;
    int n_act, n_ls, run_vs, max_vs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_stop = 0; p = 0;
        r0 = 3'b0; r1 = 3'b0; r2 = 3'b0;
        e_x = 0; e_y = 0; e_req = 0; e_fs = 0; e_ls = 0;
    endtask

    task automatic model_edge(input logic e);
        bit hs, vs;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_run) begin
            if (e) begin
                m_run = 1; m_stop = 0; p = 0;
            end
        end else if (p == FT - 1 && m_stop && !e) begin
            m_run = 0; p = 0;
        end else begin
            p = (p + 1) % FT;
            m_stop = !e;
        end
        e_x   = m_run ? p % HT : 0;
        e_y   = m_run ? p / HT : 0;
        e_req = m_run && e_x < 8 && e_y < 4;
        e_fs  = m_run && p == 0;
        e_ls  = m_run && e_x == 0;
        hs    = m_run && e_x >= 10 && e_x < 13;
        vs    = m_run && e_y >= 5 && e_y < 7;
        r2 = r1; r1 = r0; r0 = {hs, vs, e_req};
    endtask

    task automatic check_all();
        chk("a_x", 32'(a_x), 32'(e_x));
        chk("a_y", 32'(a_y), 32'(e_y));
        chk("a_req", 32'(a_req), 32'(e_req));
        chk("a_frame_start", 32'(a_fs), 32'(e_fs));
        chk("a_line_start", 32'(a_ls), 32'(e_ls));
        chk("a_running", 32'(a_run), 32'(m_run));
        chk("a_hsync", 32'(a_hs), 32'(r2[2]));
        chk("a_vsync", 32'(a_vs), 32'(r2[1]));
        chk("a_active", 32'(a_act), 32'(r2[0]));
        chk("b_x", 32'(b_x), 32'(e_x));
        chk("b_y", 32'(b_y), 32'(e_y));
        chk("b_req", 32'(b_req), 32'(e_req));
        chk("b_frame_start", 32'(b_fs), 32'(e_fs));
        chk("b_line_start", 32'(b_ls), 32'(e_ls));
        chk("b_running", 32'(b_run), 32'(m_run));
        chk("b_hsync", 32'(b_hs), 32'(!r0[2]));
        chk("b_vsync", 32'(b_vs), 32'(!r0[1]));
        chk("b_active", 32'(b_act), 32'(r0[0]));
    endtask

    task automatic cyc(input logic e);
        @(negedge pixclk);
        en = e;
        @(posedge pixclk);
        model_edge(e);
        cyc_n++;
        #1;
        check_all();
        if (win) begin
            n_act += int'(a_act);
            n_ls  += int'(a_ls);
            if (a_vs) begin
                run_vs++;
                if (run_vs > max_vs) max_vs = run_vs;
            end else begin
                run_vs = 0;
            end
        end
    endtask

    initial begin
        int i;
        int fs_cyc;
        int n_fs;
        model_reset();
        win = 0;

        // Reset values, applied asynchronously
        #1 rst_n = 1'b0;
        #1 check_all();
        cyc(1'b0);
        cyc(1'b1);
        rst_n = 1'b1;
        repeat (3) cyc(1'b0);

        // Start and one full frame of counts
        n_act = 0; n_ls = 0; run_vs = 0; max_vs = 0;
        win = 1;
        cyc(1'b1);
        chk("start_frame_start", 32'(a_fs), 32'd1);
        repeat (FT - 1) cyc(1'b1);
        win = 0;
        chk("frame_active_cycles", 32'(n_act), 32'd32);
        chk("frame_vsync_run", 32'(max_vs), 32'd32);
        chk("frame_line_starts", 32'(n_ls), 32'd8);
        cyc(1'b1);
        chk("frame_period", 32'(a_fs), 32'd1);

        // Stop while y=2: frame completes, then stays idle
        for (i = 0; i < 400 && !(m_run && p == 2 * HT + 3); i++) cyc(1'b1);
        chk("reach_y2", 32'(a_y), 32'd2);
        for (i = 0; i < 300 && a_run; i++) cyc(1'b0);
        chk("stop_done", 32'(a_run), 32'd0);
        n_fs = 0;
        repeat (40) begin
            cyc(1'b0);
            n_fs += int'(a_fs) + int'(b_fs);
        end
        chk("no_fs_after_stop", 32'(n_fs), 32'd0);

        // Resume during STOPPING keeps the frame cadence
        cyc(1'b1);
        fs_cyc = cyc_n;
        for (i = 0; i < 60; i++) cyc(1'b1);
        for (i = 0; i < 10; i++) cyc(1'b0);
        for (i = 0; i < 300; i++) begin
            cyc(1'b1);
            if (a_fs) break;
        end
        chk("resume_fs_seen", 32'(a_fs), 32'd1);
        chk("resume_period", 32'(cyc_n - fs_cyc), 32'(FT));

        // Reset mid-line at x=5, y=1
        for (i = 0; i < 400 && !(m_run && p == HT + 5); i++) cyc(1'b1);
        chk("reach_x5", 32'(a_x), 32'd5);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        cyc(1'b1);
        cyc(1'b1);
        rst_n = 1'b1;
        cyc(1'b1);
        chk("post_reset_fs", 32'(a_fs), 32'd1);

        // Randomised enable patterns: holds, per-cycle toggling, noise
        for (int blk = 0; blk < 24; blk++) begin
            int mode;
            int len;
            logic e;
            mode = int'($urandom_range(0, 2));
            len  = int'($urandom_range(20, 300));
            e    = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
                if (mode == 1) e = ~e;
                else if (mode == 2) e = 1'($urandom_range(0, 1));
                cyc(e);
            end
        end
        for (i = 0; i < 300 && a_run; i++) cyc(1'b0);
        chk("final_idle", 32'(a_run), 32'd0);
        repeat (4) cyc(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
- Generates the raster sequence that drives the HDMI TMDS output path: hsync, vsync, active, plus pixel coordinates and a pixel-request strobe for the pixel source.
- Coordinates and requests lead the sync/active outputs by a fixed LEAD cycles, so a pixel source with LEAD cycles of latency lines up exactly with sync/active at the encoders.
- Start and stop happen only at frame boundaries, under control of an enable input.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, asserted level of hsync (1 = active-high)
- VS_POL, 1, asserted level of vsync
- LEAD, 2, cycles by which x/y/req lead hsync/vsync/active; range 0..15

Ports:
- pixclk  in  1  pixel clock; every register is on its rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run request (level)
- x  out  12  horizontal counter, coordinate stage
- y  out  11  vertical counter, coordinate stage
- req  out  1  pixel request: x < H_ACTIVE and y < V_ACTIVE, while running
- frame_start  out  1  one-cycle pulse at x=0, y=0 while running
- line_start  out  1  one-cycle pulse at x=0 while running
- hsync  out  1  delayed LEAD cycles, polarity per HS_POL
- vsync  out  1  delayed LEAD cycles, polarity per VS_POL
- active  out  1  equals req delayed LEAD cycles
- running  out  1  high in RUN or STOPPING

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (must be ≤ 4096); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (must be ≤ 2048).
- Line order is active, front porch, sync, back porch. The same order applies to lines within a frame.
- Reset (async, rst_n=0):
  - state IDLE; x=0, y=0; req=0, frame_start=0, line_start=0, active=0, running=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - The delay line is filled with idle values.
- All outputs are registered.
- FSM:
  - IDLE: counters held at 0, req/pulses 0. If en=1 at an edge, go to RUN. On the next cycle x=0, y=0, req=1, frame_start=1, line_start=1.
  - RUN:
    - x increments every cycle. At x=H_TOTAL-1, x wraps to 0 and y increments.
    - At y=V_TOTAL-1 with x=H_TOTAL-1, y wraps to 0.
    - If en=0 is sampled, go to STOPPING. Counting continues with no discontinuity.
  - STOPPING:
    - Counting continues. If en=1 is sampled, return to RUN seamlessly.
    - At the edge where x=H_TOTAL-1 and y=V_TOTAL-1, go to IDLE. Counters go to 0 and no frame_start is issued.
    - If en=1 on that same edge, RUN takes priority and the next frame starts immediately.
- Coordinate-stage decode, all registered together with x/y:
  - hs_raw asserted for H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw asserted for whole lines with V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC; transitions coincide with x=0.
  - In IDLE, hs_raw and vs_raw are deasserted.
- Output stage: {hs_raw, vs_raw, req} pass through a LEAD-deep shift register, then polarity is applied.
  - LEAD=0 means the outputs are the coordinate-stage values directly.
  - After entering IDLE, the delay line drains with idle values. The outputs reach idle exactly LEAD cycles after req/syncs go idle.
- Simultaneous events: en toggling every cycle never produces a partial frame. Frames always run complete.

Test Plan:
Small configuration for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=16); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); LEAD=2; polarities 1.
- Start: en 0→1 sampled at edge N → at N+1, x=0, y=0, req=1, frame_start=1. req is high for x=0..7 and low for x=8..15. active rises at N+3. hsync is high for x=10..12, observed 2 cycles later.
- Frame count: 128 cycles between frame_start pulses. Per frame: active high 32 cycles; vsync high exactly 32 consecutive cycles (lines y=5,6, shifted by 2); 8 line_start pulses.
- Stop: en→0 while y=2 → the frame completes through x=15, y=7. Then running=0, x=y=0, and no further frame_start. active/hsync/vsync are idle 2 cycles later and stay idle.
- Resume: en→0 then back to 1 during STOPPING → next frame_start exactly 128 cycles after the previous one, and running never drops.
- Reset mid-line: rst_n=0 at x=5, y=1 → outputs go to reset values without waiting for a clock edge. After release with en=1, the first frame_start occurs one cycle after the first sampling edge.
- Polarity and lead: HS_POL=0, VS_POL=0, LEAD=0 → hsync idles high and is low for x=10..12 in the same cycle as x. active equals req every cycle.
